minhash_idx_serializer: RTL and testbench
=========================================

# minhash_idx_serializer

Read-side companion to the MinHash bottom-K sorter. On a frame-done pulse it snapshots the sorter's K smallest-signature indices and the frame's element count. It then streams the valid indices out one per beat over a valid/ready interface, smallest signature (slot 0) first. A one-deep pending buffer lets the sorter start the next frame while the previous one is still draining.

## Interface
Parameters:
- INDICES_COUNT, default proj_pkg::HASHER_EXTENDER_INDICES_COUNT: number of sorter slots (K), ≥1.
- INDEX_W, default 8: width of one index.
- COUNT_W, default 16: width of the frame element count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_frame_done  in  1  one-cycle pulse; sample in_smallest_idx and in_frame_count this cycle.
- in_smallest_idx  in  [INDICES_COUNT-1:0][INDEX_W-1:0]  sorter slot indices; slot 0 holds the smallest signature.
- in_frame_count  in  COUNT_W  number of (signature, index) pairs pushed into the sorter this frame.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts the beat when out_valid & out_ready.
- out_idx  out  INDEX_W  index of the current beat.
- out_rank  out  $clog2(INDICES_COUNT) (min 1)  slot number of the current beat (0 = smallest).
- out_last  out  1  the current beat is the final beat of its frame.
- out_busy  out  1  active or pending frame held.
- out_overflow  out  1  sticky; a frame was dropped. Cleared only by reset.

## Operation
- Beats per frame: N = min(in_frame_count, INDICES_COUNT), computed at capture. Slots ≥ N hold sorter reset garbage and are never emitted.
- A frame with N = 0 is discarded at capture. It produces no beats and no overflow, and the active and pending slots are not touched.
- Storage is two frame slots: ACTIVE (draining) and PENDING. Each slot has a valid bit and holds {indices, N}.
- States:
  - IDLE: ACTIVE is empty.
  - SEND: ACTIVE is valid; rank counter r runs from 0 to N-1.
- Capture on in_frame_done with N>0:
  - In IDLE: load ACTIVE, set r=0, go to SEND.
  - In SEND with PENDING empty: load PENDING.
  - In SEND with PENDING full: if the last beat of ACTIVE is accepted in the same cycle, PENDING promotes to ACTIVE and the new frame loads into PENDING. Otherwise the new frame is dropped and out_overflow is set.
- In SEND: out_valid=1, out_idx=ACTIVE.indices[r], out_rank=r, out_last=(r==N-1). On accept, r increments.
- Last beat accepted:
  - PENDING valid: promote PENDING to ACTIVE, r=0, stay in SEND.
  - PENDING empty: go to IDLE. A capture in the same cycle follows the IDLE rule and loads ACTIVE directly.
- Output fields are stable while out_valid=1 and out_ready=0. The output never drops valid without an accept.
- out_busy = ACTIVE.valid | PENDING.valid.
- Reset mid-stream: at the next clk edge with rst_n=0, all frames are discarded and the state is IDLE.

## Timing
- Reset values: out_valid=0, out_idx=0, out_rank=0, out_last=0, out_busy=0, out_overflow=0. State IDLE, r=0, both slot valid bits 0.
- Latency: in_frame_done at edge t (IDLE) gives out_valid=1, rank 0, at edge t+1.
- With out_ready held high, a frame of N beats occupies N consecutive cycles.
- Back-to-back frames through PENDING have zero bubble: rank 0 of the next frame follows the last beat of the previous one directly.
- All outputs are registered or decoded only from registered state. There is no combinational path from out_ready or in_* to any output.

## Structure
- proj_pkg additions:
  - constant MINHASH_INDEX_W = 8.
  - typedef idx_frame_t: packed struct of {valid, count[$clog2(K+1)], indices[K][INDEX_W]}, shared by the sorter-side frame controller and this block.
- Sub-module minhash_frame_slot: one idx_frame_t register with load/clear, clamps count to K on load. It is instantiated twice, as ACTIVE and PENDING.
- Top level holds the FSM, the rank counter, and the overflow flag.

## Test plan
- K=4, indices {7,3,9,1}, count=10, ready=1 → beats 7,3,9,1 on 4 consecutive cycles; ranks 0..3; out_last only on idx 1; out_busy falls the cycle after the last accept.
- Count=2 with K=4 → exactly 2 beats (slot0, slot1), out_last on the second; count=0 → no out_valid, out_overflow stays 0.
- Ready toggling 1,0,0,1,… → out_idx/out_rank hold during stalls; every beat appears exactly once, in order.
- Frame A in flight, frame B pulsed, frame C pulsed before A finishes → A then B streamed with no gap, C dropped, out_overflow=1 and stays set.
- Frame C pulsed in the same cycle as A's last accept while B is pending → B streams next, then C, and out_overflow=0.
- rst_n=0 mid-frame at rank 2 → next cycle out_valid=0, out_busy=0; a new pulse afterwards restarts at rank 0.

Source files
------------

// File: rtl/proj_pkg.sv
// Shared project constants and types for the MinHash sorter/serializer pair.
// Width helpers keep the sorter-side controller and the serializer in agreement.
package proj_pkg;

  localparam int HASHER_EXTENDER_INDICES_COUNT = 4;
  localparam int MINHASH_INDEX_W = 8;

  function automatic int cnt_width(input int k);
    return $clog2(k + 1);
  endfunction

  function automatic int rank_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  localparam int MINHASH_CNT_W = cnt_width(HASHER_EXTENDER_INDICES_COUNT);

  typedef struct packed {
    logic                                                            valid;
    logic [MINHASH_CNT_W-1:0]                                        count;
    logic [HASHER_EXTENDER_INDICES_COUNT-1:0][MINHASH_INDEX_W-1:0]   indices;
  } idx_frame_t;

  typedef enum logic {ST_IDLE, ST_SEND} ser_state_t;

endpackage

// File: rtl/minhash_frame_slot.sv
// One captured frame: valid bit, beat count clamped to K, and the K slot indices.
// Load takes priority over clear so a slot can be emptied and refilled in one edge.
module minhash_frame_slot
  import proj_pkg::*;
#(
  parameter int K       = 4,
  parameter int INDEX_W = 8,
  parameter int COUNT_W = 16,
  localparam int CNT_W  = cnt_width(K)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_load,
  input  logic                          i_clear,
  input  logic [K-1:0][INDEX_W-1:0]     i_idx,
  input  logic [COUNT_W-1:0]            i_count,
  output logic                          o_valid,
  output logic [CNT_W-1:0]              o_count,
  output logic [K-1:0][INDEX_W-1:0]     o_idx
);

  localparam logic [COUNT_W-1:0] K_LIMIT = COUNT_W'(K);

  logic                      r_valid;
  logic [CNT_W-1:0]          r_count;
  logic [K-1:0][INDEX_W-1:0] r_idx;
  logic [CNT_W-1:0]          w_clamped;

  assign w_clamped = (i_count > K_LIMIT) ? CNT_W'(K) : CNT_W'(i_count);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_count <= '0;
      r_idx   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_count <= w_clamped;
      r_idx   <= i_idx;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_count = r_count;
  assign o_idx   = r_idx;

endmodule

// File: rtl/minhash_idx_serializer.sv
// Streams the sorter's bottom-K indices one per beat, slot 0 first, with a
// one-deep pending frame so the sorter can start its next frame early.
module minhash_idx_serializer
  import proj_pkg::*;
#(
  parameter int INDICES_COUNT = proj_pkg::HASHER_EXTENDER_INDICES_COUNT,
  parameter int INDEX_W       = 8,
  parameter int COUNT_W       = 16,
  localparam int RANK_W       = rank_width(INDICES_COUNT),
  localparam int CNT_W        = cnt_width(INDICES_COUNT)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_frame_done,
  input  logic [INDICES_COUNT-1:0][INDEX_W-1:0] in_smallest_idx,
  input  logic [COUNT_W-1:0]                    in_frame_count,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [INDEX_W-1:0]                    out_idx,
  output logic [RANK_W-1:0]                     out_rank,
  output logic                                  out_last,
  output logic                                  out_busy,
  output logic                                  out_overflow
);

  ser_state_t  r_state, w_state_next;
  logic [RANK_W-1:0] r_rank, w_rank_next;
  logic        r_overflow;

  logic        w_cap, w_accept, w_last, w_last_acc;
  logic        w_act_load, w_act_from_pend, w_act_clear;
  logic        w_pend_load, w_pend_clear, w_ovf_set;

  logic                                  w_act_valid, w_pend_valid;
  logic [CNT_W-1:0]                      w_act_count, w_pend_count;
  logic [INDICES_COUNT-1:0][INDEX_W-1:0] w_act_idx, w_pend_idx, w_act_in_idx;
  logic [COUNT_W-1:0]                    w_act_in_count;

  // Zero-count frames are ignored entirely, so they never reach the slot logic.
  assign w_cap      = in_frame_done && (in_frame_count != '0);
  assign w_accept   = (r_state == ST_SEND) && out_ready;
  assign w_last     = (CNT_W'(r_rank) + CNT_W'(1)) == w_act_count;
  assign w_last_acc = w_accept && w_last;

  always_comb begin
    w_state_next    = r_state;
    w_rank_next     = r_rank;
    w_act_load      = 1'b0;
    w_act_from_pend = 1'b0;
    w_act_clear     = 1'b0;
    w_pend_load     = 1'b0;
    w_pend_clear    = 1'b0;
    w_ovf_set       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cap) begin
          w_act_load   = 1'b1;
          w_rank_next  = '0;
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_last_acc) begin
          w_rank_next = '0;
          if (w_pend_valid) begin
            w_act_load      = 1'b1;
            w_act_from_pend = 1'b1;
            w_pend_clear    = 1'b1;
            w_pend_load     = w_cap;
          end else if (w_cap) begin
            w_act_load = 1'b1;
          end else begin
            w_act_clear  = 1'b1;
            w_state_next = ST_IDLE;
          end
        end else begin
          if (w_accept) w_rank_next = r_rank + RANK_W'(1);
          if (w_cap) begin
            if (!w_pend_valid) w_pend_load = 1'b1;
            else               w_ovf_set   = 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rank     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_rank     <= w_rank_next;
      r_overflow <= r_overflow | w_ovf_set;
    end
  end

  assign w_act_in_idx   = w_act_from_pend ? w_pend_idx : in_smallest_idx;
  assign w_act_in_count = w_act_from_pend ? COUNT_W'(w_pend_count) : in_frame_count;

  minhash_frame_slot #(.K(INDICES_COUNT), .INDEX_W(INDEX_W), .COUNT_W(COUNT_W)) u_active (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_act_load),
    .i_clear (w_act_clear),
    .i_idx   (w_act_in_idx),
    .i_count (w_act_in_count),
    .o_valid (w_act_valid),
    .o_count (w_act_count),
    .o_idx   (w_act_idx)
  );

  minhash_frame_slot #(.K(INDICES_COUNT), .INDEX_W(INDEX_W), .COUNT_W(COUNT_W)) u_pending (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_pend_load),
    .i_clear (w_pend_clear),
    .i_idx   (in_smallest_idx),
    .i_count (in_frame_count),
    .o_valid (w_pend_valid),
    .o_count (w_pend_count),
    .o_idx   (w_pend_idx)
  );

  // Outputs decode only registered state; fields read as zero when idle.
  assign out_valid    = (r_state == ST_SEND);
  assign out_idx      = out_valid ? w_act_idx[r_rank] : '0;
  assign out_rank     = out_valid ? r_rank : '0;
  assign out_last     = out_valid && w_last;
  assign out_busy     = w_act_valid | w_pend_valid;
  assign out_overflow = r_overflow;

endmodule

// File: tb/tb_minhash_idx_serializer.sv
// Scoreboard bench: expected beats are queued as frames are pulsed and
// compared against every beat the serializer presents.
module tb_minhash_idx_serializer;

  localparam int K      = proj_pkg::HASHER_EXTENDER_INDICES_COUNT;
  localparam int IW     = 8;
  localparam int CW     = 16;
  localparam int RW     = proj_pkg::rank_width(K);

  typedef struct {
    logic [IW-1:0] idx;
    logic [RW-1:0] rank;
    logic          last;
  } beat_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_frame_done = 1'b0;
  logic [K-1:0][IW-1:0] in_smallest_idx = '0;
  logic [CW-1:0]       in_frame_count = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [IW-1:0]       out_idx;
  logic [RW-1:0]       out_rank;
  logic                out_last;
  logic                out_busy;
  logic                out_overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  beat_t exp_q[$];
  int    acc_cyc[$];

  minhash_idx_serializer #(.INDICES_COUNT(K), .INDEX_W(IW), .COUNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_frame_done   (in_frame_done),
    .in_smallest_idx (in_smallest_idx),
    .in_frame_count  (in_frame_count),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_idx         (out_idx),
    .out_rank        (out_rank),
    .out_last        (out_last),
    .out_busy        (out_busy),
    .out_overflow    (out_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: every presented beat must match the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 32'(out_idx), 32'hFFFF);
      end else begin
        chk("idx",  32'(out_idx),  32'(exp_q[0].idx));
        chk("rank", 32'(out_rank), 32'(exp_q[0].rank));
        chk("last", 32'(out_last), 32'(exp_q[0].last));
        if (out_ready) begin
          $display("beat idx=%0d rank=%0d last=%0d cyc=%0d", out_idx, out_rank, out_last, cyc);
          void'(exp_q.pop_front());
          acc_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [K-1:0][IW-1:0] idx, input int count, input bit expect_drop);
    int n;
    beat_t b;
    n = (count < K) ? count : K;
    in_smallest_idx = idx;
    in_frame_count  = CW'(count);
    in_frame_done   = 1'b1;
    if (!expect_drop) begin
      for (int i = 0; i < n; i++) begin
        b.idx  = idx[i];
        b.rank = RW'(i);
        b.last = (i == n - 1);
        exp_q.push_back(b);
      end
    end
    tick();
    in_frame_done = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || out_busy) && c < budget) begin
      tick();
      c++;
    end
    chk("drain_timeout", 32'(c < budget), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  logic [K-1:0][IW-1:0] fa, fb, fc;
  int base;

  initial begin
    do_reset();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_idx",   32'(out_idx), 0);
    chk("rst_rank",  32'(out_rank), 0);
    chk("rst_last",  32'(out_last), 0);
    chk("rst_busy",  32'(out_busy), 0);
    chk("rst_ovf",   32'(out_overflow), 0);

    // Basic frame, count above K, ready held high.
    out_ready = 1'b1;
    fa[0] = 8'd7; fa[1] = 8'd3; fa[2] = 8'd9; fa[3] = 8'd1;
    base = acc_cyc.size();
    pulse(fa, 10, 1'b0);
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_rank",  32'(out_rank), 0);
    tick(); tick(); tick();
    chk("busy_before_last", 32'(out_busy), 1);
    tick();
    chk("busy_after_last", 32'(out_busy), 0);
    chk("basic_beats", 32'(acc_cyc.size() - base), 4);
    if (acc_cyc.size() - base == 4)
      chk("basic_span", 32'(acc_cyc[base+3] - acc_cyc[base]), 3);
    drain(20);

    // Short frame, then empty frame.
    fa[0] = 8'd11; fa[1] = 8'd22; fa[2] = 8'd33; fa[3] = 8'd44;
    pulse(fa, 2, 1'b0);
    drain(20);
    pulse(fa, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("zero_no_valid", 32'(out_valid), 0);
      tick();
    end
    chk("zero_no_ovf", 32'(out_overflow), 0);

    // Ready toggling 1,0,0,1: scoreboard catches any skipped or repeated beat.
    fa[0] = 8'd5; fa[1] = 8'd6; fa[2] = 8'd8; fa[3] = 8'd2;
    pulse(fa, 4, 1'b0);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    out_ready = 1'b1;
    drain(20);

    // A in flight, B pending, C dropped.
    fa[0] = 8'd10; fa[1] = 8'd11; fa[2] = 8'd12; fa[3] = 8'd13;
    fb[0] = 8'd20; fb[1] = 8'd21; fb[2] = 8'd22; fb[3] = 8'd23;
    fc[0] = 8'd30; fc[1] = 8'd31; fc[2] = 8'd32; fc[3] = 8'd33;
    base = acc_cyc.size();
    pulse(fa, 4, 1'b0);
    pulse(fb, 4, 1'b0);
    pulse(fc, 4, 1'b1);
    chk("ovf_set", 32'(out_overflow), 1);
    drain(40);
    chk("ab_beats", 32'(acc_cyc.size() - base), 8);
    if (acc_cyc.size() - base == 8)
      chk("ab_no_gap", 32'(acc_cyc[base+7] - acc_cyc[base]), 7);
    tick(); tick();
    chk("ovf_sticky", 32'(out_overflow), 1);
    do_reset();
    chk("ovf_cleared", 32'(out_overflow), 0);

    // C arrives in the same cycle as A's last accept while B is pending.
    base = acc_cyc.size();
    pulse(fa, 4, 1'b0);
    pulse(fb, 3, 1'b0);
    tick();
    tick();
    pulse(fc, 4, 1'b0);
    drain(60);
    chk("abc_beats", 32'(acc_cyc.size() - base), 11);
    if (acc_cyc.size() - base == 11)
      chk("abc_no_gap", 32'(acc_cyc[base+10] - acc_cyc[base]), 10);
    chk("abc_no_ovf", 32'(out_overflow), 0);

    // Reset mid-frame at rank 2, then restart.
    pulse(fa, 4, 1'b0);
    tick();
    tick();
    chk("mid_rank", 32'(out_rank), 2);
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_busy",  32'(out_busy), 0);
    rst_n = 1'b1;
    pulse(fb, 4, 1'b0);
    chk("restart_rank", 32'(out_rank), 0);
    chk("restart_idx",  32'(out_idx), 32'(fb[0]));
    drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
